sync_fifo_prog: RTL

Parametrised synchronous FIFO: the next-generation replacement for the fixed-geometry FIFO in the verification environment. It adds the following over the previous block:
- configurable width and depth, including non-power-of-two depths;
- programmable almost-full/almost-empty thresholds;
- a first-word-fall-through (FWFT) read mode;
- synchronous flush;
- occupancy and high-water-mark outputs.

It sits between a producer and consumer in one clock domain and is the DUT for the extended UVM environment and the updated SVA checker.

---
 rtl/sync_fifo_prog_pkg.sv | 23 ++
 rtl/sync_fifo_prog_mem.sv | 32 +++
 rtl/sync_fifo_prog.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shared_pkg
// Brief    : Shared types, defaults and helpers for the programmable FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package shared_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Count width able to represent 0..depth inclusive.
    function automatic int fifo_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem
// Brief    : DEPTH x WIDTH storage, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Storage is deliberately not reset; pointers and count define validity.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_prog
// Brief    : Synchronous FIFO with any depth, programmable thresholds,
//            standard or first-word-fall-through read, flush and high-water.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_prog
    import shared_pkg::*;
#(
    parameter int         FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int         FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int         AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int         AE_LEVEL   = 1,
    parameter fifo_mode_e MODE       = FIFO_STD,
    localparam int        CW         = fifo_cw(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         high_water
);

    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);
    localparam logic [PW-1:0] C_LAST  = PW'(FIFO_DEPTH - 1);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         hw_q, hw_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_we;
    logic [FIFO_WIDTH-1:0] mem_rdata;

    assign full        = (count_q == C_DEPTH);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= C_AF) && !full;
    assign almostempty = (count_q <= C_AE) && !empty;
    assign count       = count_q;
    assign high_water  = hw_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

    // Acceptance uses the registered flags only, so a read never frees a slot
    // for a write in the same cycle.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;
    assign mem_we = wr_acc && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_ack_d = 1'b0;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ack_d = wr_acc;
            ovf_d    = wr_en && full;
            udf_d    = rd_en && empty;
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        // Tracking the next count keeps high_water aligned with count.
        hw_d = (count_d > hw_q) ? count_d : hw_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hw_q     <= '0;
            wr_ack_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hw_q     <= hw_d;
            wr_ack_q <= wr_ack_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head word is presented directly; zero when nothing is stored.
            assign data_out = empty ? '0 : mem_rdata;
            assign valid    = !empty;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q, dout_d;
            logic                  valid_q, valid_d;

            always_comb begin
                dout_d  = dout_q;
                valid_d = 1'b0;
                if (!flush && rd_acc) begin
                    dout_d  = mem_rdata;
                    valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    dout_q  <= dout_d;
                    valid_q <= valid_d;
                end
            end

            assign data_out = dout_q;
            assign valid    = valid_q;
        end
    endgenerate

endmodule
`default_nettype wire
